// File: rtl/div_pkg.sv
// Shared definitions for the divider sequencer: state encoding, divider
// latency and the divide-by-zero quotient pattern.
package div_pkg;

  localparam int DIV_WIDTH          = 32;
  localparam int DIV_CYCLES_DEFAULT = 34;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation, used both to form operand magnitudes
// and to restore the sign of the divider results.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] fixed
);

  logic [WIDTH-1:0] negated_s;

  // 0x8000_0000 negates to itself, which is the required magnitude
  assign negated_s = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
  assign fixed     = neg ? negated_s : value;

endmodule

// File: rtl/div_sequencer.sv
// Control stage around the external 32-bit non-restoring divider: accepts a
// request, feeds magnitudes, times the fixed latency, sign-corrects into HI/LO.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_resetn,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_m,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mag_q_q, mag_q_d;
  logic [WIDTH-1:0] mag_m_q, mag_m_d;
  logic [WIDTH-1:0] raw_dvd_q, raw_dvd_d;

  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic             divisor_zero_s;
  logic             accept_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  assign dvd_neg_s      = is_signed & dividend[WIDTH-1];
  assign dvs_neg_s      = is_signed & divisor[WIDTH-1];
  assign divisor_zero_s = (divisor == {WIDTH{1'b0}});
  assign accept_s       = (state_q == ST_IDLE) & start;

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_dvd (
    .value (dividend),
    .neg   (dvd_neg_s),
    .fixed (dvd_mag_s)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_dvs (
    .value (divisor),
    .neg   (dvs_neg_s),
    .fixed (dvs_mag_s)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .value (div_quotient),
    .neg   (quot_neg_q),
    .fixed (quot_fix_s)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .value (div_remainder),
    .neg   (rem_neg_q),
    .fixed (rem_fix_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = divisor_zero_s ? ST_FIX : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the divider is held in reset whenever idle
  always_comb begin
    busy       = 1'b1;
    div_resetn = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy       = 1'b0;
        div_resetn = 1'b0;
      end
      ST_RUN: begin
        busy       = 1'b1;
        div_resetn = 1'b1;
      end
      ST_FIX: begin
        busy       = 1'b1;
        div_resetn = 1'b1;
      end
      default: begin
        busy       = 1'b0;
        div_resetn = 1'b0;
      end
    endcase
  end

  // Datapath next-state: operand capture, latency counter, result write-back
  always_comb begin
    cnt_d      = cnt_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    zero_d     = zero_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mag_q_d    = mag_q_q;
    mag_m_d    = mag_m_q;
    raw_dvd_d  = raw_dvd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_d      = {CNT_W{1'b0}};
          quot_neg_d = (dvd_neg_s & ~divisor_zero_s) ^ dvs_neg_s;
          rem_neg_d  = dvd_neg_s;
          zero_d     = divisor_zero_s;
          dbz_d      = 1'b0;
          mag_q_d    = dvd_mag_s;
          mag_m_d    = dvs_mag_s;
          raw_dvd_d  = dividend;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
      end
      ST_FIX: begin
        done_d = 1'b1;
        if (zero_q) begin
          lo_d  = DIV_ZERO_QUOT;
          hi_d  = raw_dvd_q;
          dbz_d = 1'b1;
        end else begin
          lo_d = quot_fix_s;
          hi_d = rem_fix_s;
        end
      end
      default: begin
        cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= {CNT_W{1'b0}};
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      mag_q_q    <= {WIDTH{1'b0}};
      mag_m_q    <= {WIDTH{1'b0}};
      raw_dvd_q  <= {WIDTH{1'b0}};
    end else begin
      cnt_q      <= cnt_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mag_q_q    <= mag_q_d;
      mag_m_q    <= mag_m_d;
      raw_dvd_q  <= raw_dvd_d;
    end
  end

  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_q       = mag_q_q;
  assign div_m       = mag_m_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer, with a behavioural stand-in for the
// 34-edge divider driven by the sequencer's div_q/div_m/div_resetn.
module tb_div_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_resetn;
  logic [31:0] div_q;
  logic [31:0] div_m;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  int n_cmp  = 0;
  int n_fail = 0;

  div_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .is_signed     (is_signed),
    .dividend      (dividend),
    .divisor       (divisor),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .hi            (hi),
    .lo            (lo),
    .div_resetn    (div_resetn),
    .div_q         (div_q),
    .div_m         (div_m),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider stand-in: results appear only after 34 edges out of reset
  logic [5:0] mdl_cnt;
  always @(posedge clk) begin
    if (!div_resetn) mdl_cnt <= 6'd0;
    else if (mdl_cnt != 6'd34) mdl_cnt <= mdl_cnt + 6'd1;
  end
  assign div_quotient  = (mdl_cnt == 6'd34 && div_m != 32'd0) ? div_q / div_m : 32'hDEAD_BEEF;
  assign div_remainder = (mdl_cnt == 6'd34 && div_m != 32'd0) ? div_q % div_m : 32'hBAD0_BAD0;

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'h0BAD_F00D; divisor = 32'h0000_0003; is_signed = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
    n_cmp++; if (div_resetn !== 1'b0) begin n_fail++; $display("FAIL reset_div_resetn: got %b want 0", div_resetn); end
    n_cmp++; if (div_q !== 32'd0 || div_m !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_operands: got q=%h m=%h dbz=%b want 0", div_q, div_m, div_by_zero); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat;
    issue(32'd100, 32'd7, 1'b0);
    n_cmp++; if (busy !== 1'b1 || div_resetn !== 1'b1) begin
      n_fail++; $display("FAIL unsigned_busy: got busy=%b resetn=%b want 1/1", busy, div_resetn); end
    wait_done(60, lat);
    n_cmp++; if (lat !== 35) begin n_fail++; $display("FAIL unsigned_latency: got %0d want 35", lat); end
    n_cmp++; if (lo !== 32'd14) begin n_fail++; $display("FAIL unsigned_lo: got %h want %h", lo, 32'd14); end
    n_cmp++; if (hi !== 32'd2) begin n_fail++; $display("FAIL unsigned_hi: got %h want %h", hi, 32'd2); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL unsigned_dbz: got %b want 0", div_by_zero); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL unsigned_done_pulse: got done=%b busy=%b want 0/0", done, busy); end
    n_cmp++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL unsigned_hold: got %h/%h want e/2", lo, hi); end
  endtask

  task automatic test_signed;
    int lat;
    issue(32'hFFFF_FF9C, 32'd7, 1'b1);
    n_cmp++; if (div_q !== 32'd100 || div_m !== 32'd7) begin
      n_fail++; $display("FAIL signed_magnitude: got q=%h m=%h want 64/7", div_q, div_m); end
    wait_done(60, lat);
    n_cmp++; if (lat !== 35) begin n_fail++; $display("FAIL signed_latency: got %0d want 35", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL signed_neg_lo: got %h want fffffff2", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL signed_neg_hi: got %h want fffffffe", hi); end
    issue(32'd100, 32'hFFFF_FFF9, 1'b1);
    n_cmp++; if (div_m !== 32'd7) begin n_fail++; $display("FAIL signed_divisor_mag: got %h want 7", div_m); end
    wait_done(60, lat);
    n_cmp++; if (lo !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL signed_negdiv_lo: got %h want fffffff2", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_fail++; $display("FAIL signed_negdiv_hi: got %h want 2", hi); end
  endtask

  task automatic test_overflow;
    int lat;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    n_cmp++; if (div_q !== 32'h8000_0000 || div_m !== 32'd1) begin
      n_fail++; $display("FAIL overflow_magnitude: got q=%h m=%h want 80000000/1", div_q, div_m); end
    wait_done(60, lat);
    n_cmp++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      n_fail++; $display("FAIL overflow_signed: got lo=%h hi=%h want 80000000/0", lo, hi); end
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(60, lat);
    n_cmp++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd0) begin
      n_fail++; $display("FAIL overflow_unsigned: got lo=%h hi=%h want ffffffff/0", lo, hi); end
  endtask

  task automatic test_div_by_zero;
    int lat;
    issue(32'd55, 32'd0, 1'b0);
    n_cmp++; if (div_q !== 32'd55) begin n_fail++; $display("FAIL dbz_operand: got %h want 37", div_q); end
    wait_done(10, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd55) begin
      n_fail++; $display("FAIL dbz_result: got lo=%h hi=%h want ffffffff/37", lo, hi); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
    issue(32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_done(10, lat);
    n_cmp++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL dbz_signed_raw: got lo=%h hi=%h dbz=%b want ffffffff/fffffffb/1", lo, hi, div_by_zero); end
    issue(32'd9, 32'd3, 1'b0);
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear: got %b want 0", div_by_zero); end
    wait_done(60, lat);
    n_cmp++; if (lo !== 32'd3 || hi !== 32'd0 || lat !== 35) begin
      n_fail++; $display("FAIL dbz_next_op: got lo=%h hi=%h lat=%0d want 3/0/35", lo, hi, lat); end
  endtask

  task automatic test_busy_ignore;
    int ndone;
    int lat;
    logic [31:0] lo_seen;
    logic [31:0] hi_seen;
    ndone = 0; lat = -1; lo_seen = 32'd0; hi_seen = 32'd0;
    issue(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 45; k++) begin
      start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = k; lo_seen = lo; hi_seen = hi; end
      end
      if (k == 4 || k == 19) begin
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10; is_signed = 1'b0;
        @(posedge clk); #1;
        k++;
        if (done === 1'b1) ndone++;
      end
    end
    start = 1'b0;
    n_cmp++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_single_done: got %0d want 1", ndone); end
    n_cmp++; if (lat !== 35) begin n_fail++; $display("FAIL busy_latency: got %0d want 35", lat); end
    n_cmp++; if (lo_seen !== 32'd14 || hi_seen !== 32'd2) begin
      n_fail++; $display("FAIL busy_result: got lo=%h hi=%h want e/2", lo_seen, hi_seen); end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(32'd50, 32'd5, 1'b0);
    wait_done(60, lat);
    issue(32'd17, 32'd4, 1'b0);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy, done); end
    n_cmp++; if (lo !== 32'd10 || hi !== 32'd0) begin
      n_fail++; $display("FAIL b2b_first: got lo=%h hi=%h want a/0", lo, hi); end
    wait_done(60, lat);
    n_cmp++; if (lat !== 35 || lo !== 32'd4 || hi !== 32'd1) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d lo=%h hi=%h want 35/4/1", lat, lo, hi); end
  endtask

  task automatic test_reset_mid_op;
    int ndone;
    int lat;
    ndone = 0;
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || div_resetn !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: got busy=%b hi=%h lo=%h resetn=%b done=%b want 0", busy, hi, lo, div_resetn, done); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", ndone); end
    issue(32'd9, 32'd3, 1'b0);
    wait_done(60, lat);
    n_cmp++; if (lat !== 35 || lo !== 32'd3 || hi !== 32'd0) begin
      n_fail++; $display("FAIL abort_recover: got lat=%0d lo=%h hi=%h want 35/3/0", lat, lo, hi); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_by_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
